// File: rtl/note_sequencer.sv
// note_sequencer
//   Song-playback front end for the piano buzzer stage. Holds a writable song
//   memory of 8-bit note words ([4:0] key code, [7:5] beats-1) and, on start,
//   plays it by driving key/key_on for the buzzer tone generator. Every note
//   ends with a GAP_CYCLES silent tail so repeated pitches stay distinct.
//
//   Key codes: 0-15 pitched, 30 END marker, 16-29 and 31 rest.
//
//   Parameters:
//     BEAT_CYCLES  clk cycles per beat (must exceed GAP_CYCLES)
//     GAP_CYCLES   silent cycles closing each note (>= 1)
//     ADDR_W       song memory address width (depth 2**ADDR_W)
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     wr_en/wr_addr/wr_data  song memory write, ignored while busy
//     start               level-sampled, starts playback at address 0 when idle
//     stop                aborts playback (wins over start)
//     loop                restart at end of song (only with NOTE_SEQ_LOOP_EN)
//     key, key_on         pitch index and tone gate to the buzzer
//     busy                high whenever not idle
//     note_idx            address of the note currently sounding
//     done                one-cycle pulse at end of song
//
//   Build option: define NOTE_SEQ_LOOP_EN to add the loop port.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              stop,
`ifdef NOTE_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [4:0]        key,
  output logic              key_on,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_NOTE,
    S_GAP,
    S_END
  } state_t;

  localparam logic [31:0]       BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0]       TAIL_LAST = 32'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [4:0]        KEY_END   = 5'd30;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        beat_cnt;
  logic [31:0]       cyc_cnt;
  logic [7:0]        rd_word;
  logic              loop_go;

  logic [7:0] mem [2**ADDR_W];

`ifdef NOTE_SEQ_LOOP_EN
  assign loop_go = loop;
`else
  assign loop_go = 1'b0;
`endif

  // Song memory: synchronous read, contents not reset. busy is low exactly
  // when the FSM is idle, so it doubles as the write-enable qualifier.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    rd_word <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      beat_cnt <= '0;
      cyc_cnt  <= '0;
      key      <= '0;
      key_on   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state  <= S_IDLE;
        key_on <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              addr  <= '0;
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            cyc_cnt  <= '0;
            beat_cnt <= rd_word[7:5];
            if (rd_word[4:0] == KEY_END) begin
              done  <= 1'b1;
              state <= S_END;
            end else begin
              note_idx <= addr;
              state    <= S_NOTE;
              // Rests keep the previous key so the buzzer sees a stable index.
              if (!rd_word[4]) begin
                key    <= rd_word[4:0];
                key_on <= 1'b1;
              end else begin
                key_on <= 1'b0;
              end
            end
          end
          S_NOTE: begin
            // Whole beats are counted down first; the last beat is shortened
            // by the gap so the full note still spans (dur+1) beats.
            if (beat_cnt != 3'd0) begin
              if (cyc_cnt == BEAT_LAST) begin
                cyc_cnt  <= '0;
                beat_cnt <= beat_cnt - 3'd1;
              end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
              end
            end else if (cyc_cnt == TAIL_LAST) begin
              cyc_cnt <= '0;
              key_on  <= 1'b0;
              state   <= S_GAP;
            end else begin
              cyc_cnt <= cyc_cnt + 32'd1;
            end
          end
          S_GAP: begin
            if (cyc_cnt == GAP_LAST) begin
              cyc_cnt <= '0;
              if (addr == ADDR_MAX) begin
                done  <= 1'b1;
                state <= S_END;
              end else begin
                addr  <= addr + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 32'd1;
            end
          end
          S_END: begin
            if (loop_go) begin
              addr  <= '0;
              state <= S_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            key_on <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
